// File: rtl/i2c_slave_teddy.sv
// i2c_slave_teddy: I2C responder with filtered SCL/SDA, 7-bit address match, write byte stream and show-ahead FIFO reads.
// Define I2C_SLAVE_STRETCH_EN to hold SCL low on an empty FIFO instead of sending 0xFF.
module i2c_slave_teddy #(
    parameter int FILT = 3
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [6:0] dev_addr,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oen,
    output logic       sda_oen,
    input  logic [7:0] data_in,
    input  logic       tx_empty,
    output logic       rd_req,
    output logic [7:0] out_data,
    output logic       out_ena,
    output logic       out_first,
    output logic       busy,
    output logic       r_nw,
    output logic       underrun
);
    typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, IGNORE, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STRETCH} state_t;
    state_t state;
    logic [1:0] scl_s, sda_s;
    logic [FILT-1:0] scl_h, sda_h;
    logic scl_f, sda_f, scl_n, sda_n;
    logic scl_rise, scl_fall, start, stop, need_byte;
    logic [2:0] cnt;
    logic [6:0] sh, tx_sh;
    logic match, first;

    // a level is accepted only once the whole history window agrees
    assign scl_n = &scl_h ? 1'b1 : (|scl_h ? scl_f : 1'b0);
    assign sda_n = &sda_h ? 1'b1 : (|sda_h ? sda_f : 1'b0);
    assign scl_rise = scl_n & ~scl_f;
    assign scl_fall = ~scl_n & scl_f;
    assign start = scl_f & scl_n & sda_f & ~sda_n;
    assign stop = scl_f & scl_n & ~sda_f & sda_n;
    assign need_byte = state == STRETCH || (scl_fall && (state == RD_ACK || (state == ADDR_ACK && sda_oen && r_nw)));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_s <= '1;
            sda_s <= '1;
            scl_h <= '1;
            sda_h <= '1;
            scl_f <= 1'b1;
            sda_f <= 1'b1;
        end else begin
            scl_s <= {scl_s[0], scl_i};
            sda_s <= {sda_s[0], sda_i};
            scl_h <= FILT'({scl_h, scl_s[1]});
            sda_h <= FILT'({sda_h, sda_s[1]});
            scl_f <= scl_n;
            sda_f <= sda_n;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            cnt <= '0;
            sh <= '0;
            tx_sh <= '0;
            match <= 1'b0;
            first <= 1'b0;
            sda_oen <= 1'b0;
            rd_req <= 1'b0;
            out_data <= '0;
            out_ena <= 1'b0;
            out_first <= 1'b0;
            busy <= 1'b0;
            r_nw <= 1'b0;
            underrun <= 1'b0;
        end else begin
            rd_req <= 1'b0;
            out_ena <= 1'b0;
            out_first <= 1'b0;
            underrun <= 1'b0;
            case (state)
                ADDR: if (scl_rise) begin
                    sh <= {sh[5:0], sda_f};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd6) match <= {sh[5:0], sda_f} == dev_addr;
                    if (cnt == 3'd7) state <= ADDR_ACK;
                end
                // sda_oen doubles as the phase marker: first fall starts the ACK, second ends it
                ADDR_ACK: if (scl_fall) begin
                    if (!sda_oen) begin
                        if (match) begin
                            sda_oen <= 1'b1;
                            busy <= 1'b1;
                            r_nw <= sh[0];
                            first <= 1'b1;
                        end else
                            state <= IGNORE;
                    end else begin
                        sda_oen <= 1'b0;
                        state <= WR_BYTE;
                    end
                end
                WR_BYTE: if (scl_rise) begin
                    sh <= {sh[5:0], sda_f};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= WR_ACK;
                        out_ena <= 1'b1;
                        out_data <= {sh, sda_f};
                        out_first <= first;
                        first <= 1'b0;
                    end
                end
                WR_ACK: if (scl_fall) begin
                    sda_oen <= !sda_oen;
                    if (sda_oen) state <= WR_BYTE;
                end
                RD_BYTE: if (scl_fall) begin
                    cnt <= cnt + 3'd1;
                    tx_sh <= {tx_sh[5:0], 1'b1};
                    sda_oen <= cnt == 3'd7 ? 1'b0 : !tx_sh[6];
                    if (cnt == 3'd7) state <= RD_ACK;
                end
                RD_ACK: if (scl_rise && sda_f) state <= IGNORE;
                default: ;
            endcase
            if (need_byte) begin
                cnt <= '0;
                rd_req <= !tx_empty;
                sda_oen <= !tx_empty && !data_in[7];
`ifdef I2C_SLAVE_STRETCH_EN
                state <= tx_empty ? STRETCH : RD_BYTE;
                tx_sh <= data_in[6:0];
`else
                state <= RD_BYTE;
                underrun <= tx_empty;
                tx_sh <= tx_empty ? 7'h7F : data_in[6:0];
`endif
            end
            if (start) begin
                state <= ADDR;
                cnt <= '0;
                sda_oen <= 1'b0;
            end
            if (stop) begin
                state <= IDLE;
                sda_oen <= 1'b0;
                busy <= 1'b0;
            end
        end
    end

`ifdef I2C_SLAVE_STRETCH_EN
    // SCL is let go one clk after the load that ends the stretch
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            scl_oen <= 1'b0;
        else
            scl_oen <= !start && !stop && (state == STRETCH || (need_byte && tx_empty));
    end
`else
    assign scl_oen = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_slave_teddy.sv
// tb_i2c_slave_teddy: directed bench with an open-drain bus model, a bit-banged master and a small show-ahead FIFO.
module tb_i2c_slave_teddy;
    localparam int Q = 10;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic [6:0] dev_addr = 7'h50;
    logic scl_m = 1'b1, sda_m = 1'b1;
    logic scl_i, sda_i, scl_oen, sda_oen;
    logic [7:0] data_in, out_data;
    logic tx_empty, rd_req, out_ena, out_first, busy, r_nw, underrun;
    logic [7:0] mem [4];
    int wr_ptr = 0, rd_ptr = 0;
    int n_ena = 0, n_rd = 0, n_und = 0;
    logic [8:0] ena_log [16];
    int n_chk = 0, n_fail = 0;

    i2c_slave_teddy #(.FILT(3)) dut (
        .clk(clk), .n_rst(n_rst), .dev_addr(dev_addr),
        .scl_i(scl_i), .sda_i(sda_i), .scl_oen(scl_oen), .sda_oen(sda_oen),
        .data_in(data_in), .tx_empty(tx_empty), .rd_req(rd_req),
        .out_data(out_data), .out_ena(out_ena), .out_first(out_first),
        .busy(busy), .r_nw(r_nw), .underrun(underrun)
    );

    always #5 clk = ~clk;
    assign scl_i = scl_m & ~scl_oen;
    assign sda_i = sda_m & ~sda_oen;
    assign tx_empty = wr_ptr == rd_ptr;
    assign data_in = mem[rd_ptr[1:0]];

    always @(negedge clk) begin
        if (out_ena) begin
            ena_log[n_ena[3:0]] = {out_first, out_data};
            n_ena++;
        end
        if (rd_req) begin
            n_rd++;
            rd_ptr++;
        end
        if (underrun) n_und++;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[1:0]] = d;
        wr_ptr++;
    endtask

    task automatic start_c();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic stop_c();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic mbit(input logic b, output logic r);
        sda_m = b; wq();
        scl_m = 1'b1;
        for (int i = 0; i < 4000 && !scl_i; i++) @(negedge clk);
        if (!scl_i) chk("scl_release", 32'(scl_i), 32'd1);
        wq(); r = sda_i; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) mbit(d[i], r);
        mbit(1'b1, r);
        ack = !r;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            mbit(1'b1, r);
            d[i] = r;
        end
        mbit(nack, r);
    endtask

    initial begin
        logic ack, r;
        logic [7:0] d;
        int b_ena, b_rd, b_und;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({scl_oen, sda_oen, rd_req, out_ena, out_first, busy, r_nw, underrun, out_data}), 32'd0);
        n_rst = 1'b1;
        wq();

        // write 0x12, 0x34 to 0x50
        b_ena = n_ena;
        start_c();
        send_byte(8'hA0, ack); chk("wr_addr_ack", 32'(ack), 32'd1);
        send_byte(8'h12, ack); chk("wr_b0_ack", 32'(ack), 32'd1);
        chk("wr_r_nw", 32'(r_nw), 32'd0);
        send_byte(8'h34, ack); chk("wr_b1_ack", 32'(ack), 32'd1);
        chk("wr_busy", 32'(busy), 32'd1);
        stop_c(); wq();
        chk("wr_busy_after_stop", 32'(busy), 32'd0);
        chk("wr_ena_count", 32'(n_ena - b_ena), 32'd2);
        chk("wr_log0", 32'(ena_log[b_ena[3:0]]), 32'h112);
        chk("wr_log1", 32'(ena_log[4'(b_ena + 1)]), 32'h034);
        chk("wr_out_data", 32'(out_data), 32'h34);

        // read two bytes, NACK the last
        push(8'h5A); push(8'hC3);
        b_rd = n_rd;
        start_c();
        send_byte(8'hA1, ack); chk("rd_addr_ack", 32'(ack), 32'd1);
        chk("rd_r_nw", 32'(r_nw), 32'd1);
        read_byte(1'b0, d); chk("rd_byte0", 32'(d), 32'h5A);
        read_byte(1'b1, d); chk("rd_byte1", 32'(d), 32'hC3);
        chk("rd_sda_after_nack", 32'(sda_oen), 32'd0);
        stop_c(); wq();
        chk("rd_req_count", 32'(n_rd - b_rd), 32'd2);

        // address mismatch
        b_ena = n_ena;
        start_c();
        send_byte(8'hA2, ack); chk("mm_no_ack", 32'(ack), 32'd0);
        chk("mm_busy", 32'(busy), 32'd0);
        stop_c(); wq();
        chk("mm_no_ena", 32'(n_ena - b_ena), 32'd0);

        // write then repeated START into a read
        b_ena = n_ena; b_rd = n_rd;
        push(8'h99);
        start_c();
        send_byte(8'hA0, ack); chk("rs_wr_addr_ack", 32'(ack), 32'd1);
        send_byte(8'h07, ack); chk("rs_wr_ack", 32'(ack), 32'd1);
        chk("rs_r_nw_wr", 32'(r_nw), 32'd0);
        start_c();
        send_byte(8'hA1, ack); chk("rs_rd_addr_ack", 32'(ack), 32'd1);
        chk("rs_r_nw_rd", 32'(r_nw), 32'd1);
        read_byte(1'b1, d); chk("rs_rd_byte", 32'(d), 32'h99);
        stop_c(); wq();
        chk("rs_ena_count", 32'(n_ena - b_ena), 32'd1);
        chk("rs_log", 32'(ena_log[b_ena[3:0]]), 32'h107);
        chk("rs_rd_count", 32'(n_rd - b_rd), 32'd1);

        // read with an empty FIFO
        b_rd = n_rd; b_und = n_und;
        start_c();
        send_byte(8'hA1, ack); chk("em_addr_ack", 32'(ack), 32'd1);
`ifdef I2C_SLAVE_STRETCH_EN
        fork
            read_byte(1'b1, d);
            begin
                repeat (40) @(negedge clk);
                chk("em_scl_held", 32'(scl_oen), 32'd1);
                push(8'h3C);
            end
        join
        chk("em_byte", 32'(d), 32'h3C);
        chk("em_underrun", 32'(n_und - b_und), 32'd0);
        chk("em_rd_count", 32'(n_rd - b_rd), 32'd1);
`else
        read_byte(1'b1, d);
        chk("em_byte", 32'(d), 32'hFF);
        chk("em_underrun", 32'(n_und - b_und), 32'd1);
        chk("em_rd_count", 32'(n_rd - b_rd), 32'd0);
`endif
        stop_c(); wq();

        // reset during the 4th bit of a read (0xE5: 4th bit is 0, slave drives low)
        push(8'hE5);
        start_c();
        send_byte(8'hA1, ack); chk("rst_addr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 3; i++) mbit(1'b1, r);
        sda_m = 1'b1; wq();
        chk("rst_pre_drive", 32'(sda_oen), 32'd1);
        n_rst = 1'b0;
        #1;
        chk("rst_async_outputs", 32'({scl_oen, sda_oen, rd_req, out_ena, out_first, busy, r_nw, underrun, out_data}), 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        wq();
        b_ena = n_ena;
        start_c();
        send_byte(8'hA0, ack); chk("post_rst_addr_ack", 32'(ack), 32'd1);
        send_byte(8'h55, ack); chk("post_rst_ack", 32'(ack), 32'd1);
        stop_c(); wq();
        chk("post_rst_log", 32'(ena_log[b_ena[3:0]]), 32'h155);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_slave_teddy.md
# i2c_slave_teddy

I2C responder (slave) engine, the bus-side counterpart of the I2C master engine used by the interface blocks. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a programmable 7-bit device address and ACKs it. Written bytes go out as a byte stream; read bytes are fetched from a show-ahead FIFO. It sits behind the same tri-state pad logic as the master, driving lines only low through output-enable signals.

## Interface
- FILT, 3: glitch-filter depth; a synchronized line level is accepted only after FILT consecutive equal samples.
- clk  in  1  system clock.
- n_rst  in  1  asynchronous, active-low reset.
- dev_addr  in  7  own address; sampled at the 7th address bit.
- scl_i, sda_i  in  1 each  raw pad levels.
- scl_oen, sda_oen  out  1 each  1 = pull line low, 0 = release.
- data_in  in  8  head of the TX FIFO (show-ahead).
- tx_empty  in  1  TX FIFO empty.
- rd_req  out  1  one-cycle pop of the TX FIFO.
- out_data  out  8  received byte.
- out_ena  out  1  one-cycle strobe; out_data valid.
- out_first  out  1  with out_ena: first byte after the address.
- busy  out  1  addressed transaction in progress (address ACK to STOP).
- r_nw  out  1  direction of the current transaction.
- underrun  out  1  one-cycle pulse: read byte needed while tx_empty.

## Operation
- Input path: 2-flop synchronizer, then a FILT-deep filter, then edge detection on filtered SCL/SDA.
- START: filtered SDA falls while SCL is high. Accepted from any state, including a repeated START. Goes to ADDR and clears the bit counter.
- STOP: filtered SDA rises while SCL is high. Goes to IDLE from any state, releases both lines and clears busy.
- States:
  - IDLE.
  - ADDR: shift 8 bits MSB first on SCL rising.
  - ADDR_ACK: on address match, set r_nw from bit 0, busy=1, drive ACK. On mismatch, go to IGNORE.
  - IGNORE: wait for START or STOP.
  - WR_BYTE: shift 8 bits, then WR_ACK.
  - WR_ACK: raise out_ena with out_data, always ACK, back to WR_BYTE.
  - RD_BYTE: shift data out MSB first.
  - RD_ACK: sample the master's ACK on SCL rising. ACK (0) loads the next byte. NACK (1) goes to IGNORE.
- ACK driving: sda_oen=1 from the 8th SCL falling edge to the 9th SCL falling edge.
- Read data: the byte is loaded into the shift register at the SCL falling edge that ends ADDR_ACK or RD_ACK, with rd_req=1 in that cycle if !tx_empty. If tx_empty, the byte is 0xFF and underrun pulses (unless stretching is compiled in, see Configuration).
- sda_oen follows the inverse of the current data bit. It changes only on detected SCL falling edges.
- Bit and byte counters are 3 bits. They wrap 7→0 at each byte boundary. There is no limit on the number of bytes.
- The slave never drives SDA during a START or STOP. On a bus error (a START mid-byte), partial bytes are discarded with no out_ena.

## Timing
- Reset: all outputs 0, state IDLE, lines released. Reset mid-transfer releases SDA/SCL in the same cycle; this path is asynchronous.
- Pin-to-detection latency: 2 + FILT clk cycles.
- sda_oen updates 1 clk after the detected SCL falling edge. Hold time on the bus is therefore at least (3 + FILT) clk.
- out_ena fires 1 clk after the detected 8th SCL rising edge of a write byte. out_first is high only for the first byte after the address.
- rd_req and the shift load happen in the same cycle. data_in must be valid while tx_empty=0.
- With tx_empty=0 held constant, consecutive rd_req pulses are at least 9 SCL periods apart.

## Configuration
- I2C_SLAVE_STRETCH_EN defined: if a read byte is needed while tx_empty=1, set scl_oen=1 and hold SCL low until tx_empty=0. Then load the byte, pulse rd_req, and release SCL 1 clk later; underrun is never asserted. A STOP, START or reset releases SCL immediately.
- I2C_SLAVE_STRETCH_EN not defined: scl_oen is tied to 0, an empty FIFO sends 0xFF and underrun pulses.

## Test plan
- Write: dev_addr=0x50; master writes 0xA0, 0x12, 0x34, then STOP. Required: ACK on all three bytes; out_ena twice with 0x12 (out_first=1), then 0x34; busy=1 until the STOP.
- Read: FIFO holds 0x5A, 0xC3; master sends 0xA1, reads 2 bytes ending with NACK. Required: bus sees 0x5A, 0xC3; exactly 2 rd_req; no SDA drive after the NACK.
- Mismatch: master sends 0xA2. Required: no ACK (SDA released on the 9th clock), busy=0, no out_ena.
- Repeated START: write 0xA0, 0x07, then repeated START, 0xA1, read 1 byte. Required: out_ena with 0x07; r_nw goes 0→1; one rd_req.
- Empty read: FIFO empty, master sends 0xA1. Without the macro: 0xFF on the bus and one underrun pulse. With the macro: SCL held low until the FIFO is written, then the byte is sent.
- Reset mid-byte: n_rst asserted during the 4th bit of a read. Required: sda_oen=scl_oen=0 immediately, all outputs 0; the next START/0xA0 is handled normally.
